prio_encoder_4_2: RTL
=====================

Name: prio_encoder_4_2

Overview:
- Registered 4-to-2 priority encoder with sticky request capture and a valid/ack handshake; the inverse of the team's 2-to-4 decoder.
- Collects up to four request lines into a pending register and presents the index of the highest-priority pending request as a 2-bit code.
- Holds that code until the consumer acknowledges it, then clears the served bit.
- Sits between request sources (buttons, interrupt-style flags) and a consumer that decodes the index back to a one-hot select.

Parameters:
- LSB_PRIO, 1, priority order. 1: req[0] is highest priority. 0: req[3] is highest priority.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines, sampled every clock edge; a single-cycle pulse is sufficient.
- ack  input  1  consumer accepts the current code; honoured only while valid=1.
- code  output  2  binary index of the granted request, registered.
- valid  output  1  code is meaningful, registered.
- pending  output  4  current pending-request register, for debug and status.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1:
  - pending=4'b0000, code=2'b00, valid=0, FSM=IDLE.
  - Reset takes effect immediately, including mid-handshake; no grant survives it.
- Pending update, every edge: pending <= (pending & ~clr_mask) | req.
  - clr_mask is one-hot(code) only when valid=1 and ack=1; otherwise it is 0.
  - Set wins over clear: if req[k] and the ack of code k occur in the same cycle, pending[k] stays 1.
- Priority encode, combinational on the pending register only (never on raw req):
  - LSB_PRIO=1: lowest set index wins.
  - LSB_PRIO=0: highest set index wins.
  - pending=0 means no candidate.
- FSM states: IDLE, GRANT.
  - IDLE: if pending!=0, then at the next edge code<=encode(pending), valid<=1, go to GRANT. Otherwise stay in IDLE with valid=0 and code holding its last value.
  - GRANT: valid=1 and code held stable, even if a higher-priority request arrives meanwhile.
  - GRANT with ack=1: clear pending[code] at this edge, valid<=0, go to IDLE.
  - GRANT with ack=0: remain in GRANT.
- Latency:
  - req asserted in cycle N: pending bit is visible after edge N+1; code/valid are visible after edge N+2.
  - After an ack there is one mandatory bubble cycle with valid=0 before the next grant.
  - Maximum throughput is one grant per 2 cycles.
- Boundary conditions:
  - ack while valid=0: ignored, with no effect on pending.
  - Re-requesting a bit that is already pending: no effect; requests are not counted.
  - All four bits pending: served one at a time in priority order, each requiring its own ack.
  - A request for the granted bit arriving during GRANT without ack: merged, no effect.
  - A request for the granted bit arriving in the ack cycle: the bit stays pending and is re-granted after the bubble.
  - code is X-free at all times after reset.

Decomposition:
- Shared package (prio_enc_pkg):
  - state enum {IDLE, GRANT}.
  - Localparams REQ_W=4 and CODE_W=2.
  - encode function, or its constants.
- One natural sub-module: prio_enc_4_2_comb.
  - Pure combinational encoder: pending[3:0] and LSB_PRIO in; idx[1:0] and any out.
  - Instantiated once; the top level holds the pending register, the FSM and the output registers.

Test Plan:
- Reset mid-grant: valid=1, code=2, then assert rst asynchronously between edges -> valid=0, code=0, pending=0 immediately; after release, no grant until a new req.
- Single pulse: req=4'b0100 for one cycle at N -> pending=0100 after N+1; code=2, valid=1 after N+2, held for 5 cycles without ack. Ack -> pending=0000 and valid=0 next cycle.
- Simultaneous requests, LSB_PRIO=1: req=4'b1010 -> grant code=1. Ack, one bubble, then grant code=3. Ack -> pending=0, valid stays 0.
- No preemption: in GRANT with code=3, pulse req=4'b0001 -> code stays 3 until ack; after the bubble, code=0.
- Set-wins collision: in GRANT with code=1, apply ack=1 and req=4'b0010 in the same cycle -> pending[1] stays 1; after the bubble, code=1 and valid=1 again. Ack with valid=0 -> pending unchanged.
- LSB_PRIO=0 instance: req=4'b1010 -> code=3 first, then code=1; req=4'b1111 -> grant sequence 3, 2, 1, 0, one per ack.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered 4-to-2 priority encoder.
// Holds the FSM state type, the bus widths and the one-hot helper used for clearing.
package prio_enc_pkg;

   localparam int REQ_W  = 4;
   localparam int CODE_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Expands a granted index back into the pending bit it refers to.
   function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] c);
      return REQ_W'(1) << c;
   endfunction

endpackage

// File: rtl/prio_enc_4_2_comb.sv
// Pure combinational 4-to-2 priority encoder over the pending register.
// LSB_PRIO=1 selects the lowest set index, LSB_PRIO=0 the highest.
module prio_enc_4_2_comb
   import prio_enc_pkg::*;
#(
   parameter bit LSB_PRIO = 1'b1
) (
   input  logic [REQ_W-1:0]  pending,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      idx = '0;
      any = |pending;
      // The loop direction makes the winning index the last one written.
      if (LSB_PRIO) begin
         for (int i = REQ_W - 1; i >= 0; i--) begin
            if (pending[i]) idx = CODE_W'(i);
         end
      end else begin
         for (int i = 0; i < REQ_W; i++) begin
            if (pending[i]) idx = CODE_W'(i);
         end
      end
   end

endmodule

// File: rtl/prio_encoder_4_2.sv
// Registered 4-to-2 priority encoder with sticky request capture and a valid/ack handshake.
// The granted code is held until acknowledged; each grant is followed by a one-cycle bubble.
module prio_encoder_4_2
   import prio_enc_pkg::*;
#(
   parameter bit LSB_PRIO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REQ_W-1:0]  req,
   input  logic              ack,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic [REQ_W-1:0]  pending
);

   state_t              state_q, state_d;
   logic [REQ_W-1:0]    pending_q, pending_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                valid_q, valid_d;
   logic [REQ_W-1:0]    clr_mask;
   logic [CODE_W-1:0]   enc_idx;
   logic                enc_any;

   // Encoding looks only at the registered pending bits, never at raw req.
   prio_enc_4_2_comb #(
      .LSB_PRIO (LSB_PRIO)
   ) u_enc (
      .pending (pending_q),
      .idx     (enc_idx),
      .any     (enc_any)
   );

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      valid_d  = valid_q;
      clr_mask = '0;

      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (enc_any) begin
               code_d  = enc_idx;
               valid_d = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // Code stays frozen here even if a higher-priority request shows up.
            if (valid_q && ack) begin
               clr_mask = onehot(code_q);
               valid_d  = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Set wins over clear: a new req for the served bit keeps it pending.
      pending_d = (pending_q & ~clr_mask) | req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         pending_q <= pending_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
      end
   end

   assign code    = code_q;
   assign valid   = valid_q;
   assign pending = pending_q;

endmodule
